// File: rtl/serial_data_rx.sv
// I2S ADC-path deserializer: samples din on bclk rises, assembles MSB-first words, writes them to the RX FIFO.
// winc pulses 1 mclk after the LSB rise; on wfull the word is dropped and overrun_cnt counts it.
module serial_data_rx #(
    parameter int DATA_WIDTH    = 16,
    parameter int SLOT_BITS     = 32,
    parameter bit CAPTURE_LEFT  = 1'b1,
    parameter bit CAPTURE_RIGHT = 1'b1
) (
    input  logic                  mclk,
    input  logic                  resetn,
    input  logic                  lrclk,
    input  logic                  bclk,
    input  logic                  din,
    output logic                  winc,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wfull,
    output logic [15:0]           overrun_cnt,
    output logic                  frame_err
);

    localparam int              CW      = $clog2(SLOT_BITS + 1);
    localparam logic [CW-1:0]   CNT_DW  = CW'(DATA_WIDTH);
    localparam logic [CW-1:0]   CNT_MAX = CW'(SLOT_BITS);

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_SYNC   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    bclk_q;
    logic                    lrclk_q, lrclk_d;
    logic [CW-1:0]           bitcnt_q, bitcnt_d, bitcnt_inc;
    logic                    chan_q, chan_d;
    logic [DATA_WIDTH-1:0]   sreg_q, sreg_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [15:0]             overrun_q, overrun_d;
    logic                    ferr_q, ferr_d;

    logic rise;
    logic lr_chg;
    logic chan_en;
    logic push;
    logic drop;

    assign rise    = bclk & ~bclk_q;
    assign lr_chg  = lrclk ^ lrclk_q;
    assign chan_en = chan_q ? CAPTURE_RIGHT : CAPTURE_LEFT;
    // sreg_q is stable during the push cycle: bclk stays high for at least 2 mclk after a rise.
    assign push    = done_q & chan_en & ~wfull;
    assign drop    = done_q & chan_en & wfull;
    assign bitcnt_inc = (bitcnt_q == CNT_MAX) ? bitcnt_q : bitcnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        lrclk_d  = lrclk_q;
        bitcnt_d = bitcnt_q;
        chan_d   = chan_q;
        sreg_d   = sreg_q;
        done_d   = 1'b0;
        ferr_d   = ferr_q;
        if (rise) begin
            lrclk_d = lrclk;
            case (state_q)
                ST_UNSYNC: begin
                    if (lr_chg) begin
                        state_d  = ST_SYNC;
                        bitcnt_d = '0;
                        chan_d   = lrclk;
                    end
                end
                ST_SYNC: begin
                    if (lr_chg) begin
                        bitcnt_d = '0;
                        chan_d   = lrclk;
                        if (bitcnt_q < CNT_DW) begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        bitcnt_d = bitcnt_inc;
                        if (bitcnt_inc <= CNT_DW) begin
                            sreg_d = {sreg_q[DATA_WIDTH-2:0], din};
                        end
                        if (bitcnt_inc == CNT_DW) begin
                            done_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_UNSYNC;
            endcase
        end
    end

    always_comb begin
        wdata_d   = push ? sreg_q : wdata_q;
        overrun_d = overrun_q;
        if (drop && (overrun_q != 16'hFFFF)) begin
            overrun_d = overrun_q + 16'd1;
        end
    end

    always_ff @(posedge mclk) begin
        if (!resetn) begin
            state_q   <= ST_UNSYNC;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            bitcnt_q  <= '0;
            chan_q    <= 1'b0;
            sreg_q    <= '0;
            done_q    <= 1'b0;
            wdata_q   <= '0;
            overrun_q <= '0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bclk_q    <= bclk;
            lrclk_q   <= lrclk_d;
            bitcnt_q  <= bitcnt_d;
            chan_q    <= chan_d;
            sreg_q    <= sreg_d;
            done_q    <= done_d;
            wdata_q   <= wdata_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign winc        = push;
    assign wdata       = push ? sreg_q : wdata_q;
    assign overrun_cnt = overrun_q;
    assign frame_err   = ferr_q;

endmodule

// File: tb/tb_serial_data_rx.sv
// Bench for serial_data_rx: a stereo instance and a right-only instance share one I2S stimulus stream.
module tb_serial_data_rx;

    localparam int DW = 16;

    logic        mclk = 1'b0;
    logic        resetn, lrclk, bclk, din, wfull;
    logic        winc0, winc1, ferr0, ferr1;
    logic [15:0] wdata0, wdata1, ovr0, ovr1;

    serial_data_rx #(.DATA_WIDTH(16), .SLOT_BITS(32), .CAPTURE_LEFT(1'b1), .CAPTURE_RIGHT(1'b1)) u_dut (
        .mclk(mclk), .resetn(resetn), .lrclk(lrclk), .bclk(bclk), .din(din),
        .winc(winc0), .wdata(wdata0), .wfull(wfull), .overrun_cnt(ovr0), .frame_err(ferr0)
    );

    serial_data_rx #(.DATA_WIDTH(16), .SLOT_BITS(32), .CAPTURE_LEFT(1'b0), .CAPTURE_RIGHT(1'b1)) u_dut_r (
        .mclk(mclk), .resetn(resetn), .lrclk(lrclk), .bclk(bclk), .din(din),
        .winc(winc1), .wdata(wdata1), .wfull(wfull), .overrun_cnt(ovr1), .frame_err(ferr1)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] w;
        int          c;
    } push_t;
    push_t q0[$];
    push_t q1[$];

    // Reference model: slot-level view of the I2S stream.
    logic        m_prev_lr;
    logic        m_synced;
    int          cur_len;
    logic        exp_err;
    logic [15:0] exp_ovr  [2];
    logic [15:0] exp_last [2];

    typedef struct {
        logic        lr;
        int          nbits;
        logic [15:0] word;
        logic        full;
    } vec_t;
    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_prev_lr = 1'b0;
        m_synced  = 1'b0;
        cur_len   = 0;
        exp_err   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_ovr[i]  = 16'd0;
            exp_last[i] = 16'd0;
        end
    endtask

    task automatic model_push(input logic lr, input logic [15:0] word, input logic full, input int c);
        push_t e;
        logic  en;
        e.w = word;
        e.c = c;
        for (int i = 0; i < 2; i++) begin
            en = (i == 0) ? 1'b1 : lr;
            if (en) begin
                if (!full) begin
                    if (i == 0) q0.push_back(e);
                    else        q1.push_back(e);
                    exp_last[i] = word;
                end else if (exp_ovr[i] != 16'hFFFF) begin
                    exp_ovr[i] = exp_ovr[i] + 16'd1;
                end
            end
        end
    endtask

    task automatic mon(input int i, input logic w, input logic [15:0] d);
        push_t e;
        int    have;
        have = (i == 0) ? q0.size() : q1.size();
        if (have > 0) e = (i == 0) ? q0[0] : q1[0];
        if (w) begin
            total++;
            if (have == 0) begin
                bad++;
                $display("FAIL push%0d: unexpected winc with wdata %h at cycle %0d, required no write", i, d, cyc);
            end else begin
                if (i == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                if (d !== e.w || cyc != e.c) begin
                    bad++;
                    $display("FAIL push%0d: got %h at cycle %0d, required %h at cycle %0d", i, d, cyc, e.w, e.c);
                end
            end
        end else if (have > 0 && cyc > e.c) begin
            total++;
            bad++;
            $display("FAIL push%0d: no winc seen, required %h at cycle %0d", i, e.w, e.c);
            if (i == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
    endtask

    initial begin
        forever begin
            @(negedge mclk);
            mon(0, winc0, wdata0);
            mon(1, winc1, wdata1);
        end
    end

    task automatic check_slot_end();
        @(negedge mclk);
        check("frame_err0", {31'd0, ferr0}, {31'd0, exp_err});
        check("frame_err1", {31'd0, ferr1}, {31'd0, exp_err});
        check("overrun0", {16'd0, ovr0}, {16'd0, exp_ovr[0]});
        check("overrun1", {16'd0, ovr1}, {16'd0, exp_ovr[1]});
        if (!winc0) check("wdata_hold0", {16'd0, wdata0}, {16'd0, exp_last[0]});
        if (!winc1) check("wdata_hold1", {16'd0, wdata1}, {16'd0, exp_last[1]});
    endtask

    // One lrclk half-period (or its continuation when lr is unchanged); each bclk period is 8 mclk.
    task automatic drive_slot(input logic lr, input int nbits, input logic [15:0] word, input logic full);
        logic live;
        logic d;
        int   rc;
        live = 1'b0;
        if (lr != m_prev_lr) begin
            if (m_synced && cur_len <= DW) exp_err = 1'b1;
            m_synced = 1'b1;
            live     = 1'b1;
            cur_len  = nbits;
        end
        m_prev_lr = lr;
        for (int k = 0; k < nbits; k++) begin
            if (live) d = (k >= 1 && k <= DW) ? word[DW-k] : 1'($urandom);
            else      d = word[k % DW];
            @(posedge mclk); #2;
            bclk = 1'b0; lrclk = lr; din = d; wfull = full;
            repeat (4) @(posedge mclk);
            #2;
            bclk = 1'b1;
            rc   = cyc;
            if (live && k == DW) model_push(lr, word, full, rc + 1);
            repeat (3) @(posedge mclk);
        end
        check_slot_end();
    endtask

    task automatic do_reset();
        @(posedge mclk); #2;
        resetn = 1'b0;
        @(posedge mclk); #2;
        resetn = 1'b1;
        model_reset();
        @(negedge mclk);
        check("rst_winc0", {31'd0, winc0}, 32'd0);
        check("rst_winc1", {31'd0, winc1}, 32'd0);
        check("rst_wdata0", {16'd0, wdata0}, 32'd0);
        check("rst_wdata1", {16'd0, wdata1}, 32'd0);
        check("rst_overrun0", {16'd0, ovr0}, 32'd0);
        check("rst_overrun1", {16'd0, ovr1}, 32'd0);
        check("rst_frame_err0", {31'd0, ferr0}, 32'd0);
        check("rst_frame_err1", {31'd0, ferr1}, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic lr;
        int   nb;
        tbl[0]  = '{1'b0, 32, 16'h8231, 1'b0};
        tbl[1]  = '{1'b1, 32, 16'h4567, 1'b0};
        tbl[2]  = '{1'b0, 32, 16'h9AB1, 1'b1};
        tbl[3]  = '{1'b1, 32, 16'h1234, 1'b1};
        tbl[4]  = '{1'b0, 32, 16'hCAFE, 1'b0};
        tbl[5]  = '{1'b1, 32, 16'hBABE, 1'b0};
        tbl[6]  = '{1'b0, 32, 16'h1111, 1'b1};
        tbl[7]  = '{1'b1, 32, 16'hA5A5, 1'b0};
        tbl[8]  = '{1'b0, 32, 16'h2222, 1'b1};
        tbl[9]  = '{1'b1, 32, 16'h5A5A, 1'b0};
        tbl[10] = '{1'b0, 17, 16'h0F0F, 1'b0};
        tbl[11] = '{1'b1, 16, 16'hF00D, 1'b0};
        tbl[12] = '{1'b0, 32, 16'h3C3C, 1'b0};
        tbl[13] = '{1'b1, 10, 16'hBEEF, 1'b0};
        tbl[14] = '{1'b0, 32, 16'hC3C3, 1'b0};
        tbl[15] = '{1'b1, 40, 16'h1357, 1'b0};
        tbl[16] = '{1'b0, 32, 16'h0001, 1'b0};
        tbl[17] = '{1'b1, 32, 16'h8000, 1'b0};

        resetn = 1'b1; lrclk = 1'b0; bclk = 1'b0; din = 1'b1; wfull = 1'b0;
        model_reset();
        do_reset();

        // Mid-left-slot start with all-ones data, then the first full slot after the lrclk change.
        drive_slot(1'b0, 20, 16'hFFFF, 1'b0);
        drive_slot(1'b1, 32, 16'h754F, 1'b0);

        for (int i = 0; i < 18; i++) begin
            drive_slot(tbl[i].lr, tbl[i].nbits, tbl[i].word, tbl[i].full);
        end

        // Reset at bitcnt 8 of a left slot; the interrupted word must never appear.
        drive_slot(1'b0, 9, 16'hDEAD, 1'b0);
        do_reset();
        drive_slot(1'b0, 20, 16'h0000, 1'b0);

        lr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            lr = ~lr;
            nb = ($urandom_range(0, 5) == 0) ? $urandom_range(8, 16) : $urandom_range(17, 40);
            drive_slot(lr, nb, 16'($urandom), ($urandom_range(0, 3) == 0));
        end

        repeat (20) @(negedge mclk);
        check("pending0", q0.size(), 32'd0);
        check("pending1", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
